frame_source_arbiter: RTL and testbench
=======================================

FRAME_SOURCE_ARBITER -- requirements
Module: frame_source_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000: cycles with no accepted word from the granted source before a frame is aborted.
REQ-002 Port clk  in  1  single clock; all logic on rising edge.
REQ-003 Port reset  in  1  synchronous, active-high reset.
REQ-004 Port src_sel  in  1  requested source: 0 = camera, 1 = debug pattern.
REQ-005 Port cam_data  in  17  camera queue word; bit16 = marker flag.
REQ-006 Port cam_wr_en  in  1  camera word valid; the camera cannot be stalled.
REQ-007 Port dbg_data  in  17  debug-pattern queue word, same format.
REQ-008 Port dbg_wr_en  in  1  debug word valid.
REQ-009 Port dbg_full  out  1  back-pressure to the debug generator.
REQ-010 Port queue_full  in  1  downstream frame queue full.
REQ-011 Port queue_data  out  17  registered word to the queue.
REQ-012 Port queue_wr_en  out  1  registered queue write strobe.
REQ-013 Port active_src  out  2  00 = none, 01 = camera, 10 = debug.
REQ-014 Port frame_aborted  out  1  one-cycle pulse when an abort end marker is written.

Function
REQ-015 Markers: FRAME_START 17'h10000, ROW_START 17'h10001, FRAME_END 17'h1FFFF.
REQ-016 Output latency is 1 cycle: an input word accepted in cycle N appears on queue_data/queue_wr_en in cycle N+1.
REQ-017 States: IDLE, CAM_FRAME, DBG_FRAME, ABORT.
REQ-018 IDLE: src_sel is sampled every cycle; only FRAME_START from the selected source, with queue_full=0, is forwarded; the FSM then moves to CAM_FRAME or DBG_FRAME; all other words from either source are discarded.
REQ-019 CAM_FRAME: every cam word with cam_wr_en=1 and queue_full=0 is forwarded; a cam word arriving while queue_full=1 is dropped; all dbg words are discarded.
REQ-020 DBG_FRAME: every dbg word with dbg_wr_en=1 and queue_full=0 is forwarded; all cam words are discarded.
REQ-021 dbg_full = queue_full when in DBG_FRAME, or when in IDLE with src_sel=1; dbg_full = 1 in all other cases.
REQ-022 A FRAME_END accepted from the granted source is forwarded, and the FSM returns to IDLE the same cycle.
REQ-023 A FRAME_END from the granted source that arrives while queue_full=1, or a FRAME_START arriving mid-frame, moves the FSM to ABORT; that word is not forwarded.
REQ-024 The timeout counter clears on entry to a frame state and on each accepted word; when it reaches TIMEOUT_CYCLES the FSM moves to ABORT.
REQ-025 ABORT: the block waits for queue_full=0, writes FRAME_END, pulses frame_aborted in the same cycle as that write, then goes to IDLE.
REQ-026 A change of src_sel during a frame or in ABORT is ignored until IDLE.
REQ-027 queue_wr_en is low in every cycle in which nothing is forwarded or inserted.
REQ-028 active_src reflects the state registered in the current cycle: IDLE and ABORT show 00.

Reset
REQ-029 Reset puts the FSM in IDLE and sets queue_data=0, queue_wr_en=0, frame_aborted=0, active_src=00, the timeout counter to 0, and any statistics counters to 0.
REQ-030 Reset asserted mid-frame emits no end marker; the downstream consumer resynchronises on the next FRAME_START.

Configuration
REQ-031 With FRAME_SOURCE_STATS_EN defined, outputs frames_done (16-bit: FRAME_END words written, including aborts) and words_dropped (16-bit: camera words lost to queue_full) are present; both wrap modulo 2^16.
REQ-032 Without FRAME_SOURCE_STATS_EN, those ports and their counters do not exist, and all other behaviour is identical.

Structure
REQ-033 The marker constants and the arbiter state enum belong in shared package frame_queue_pkg; the debug generator and camera capture blocks use the same package.
REQ-034 The timeout counter is a sub-module, frame_timeout_counter (inputs clear and enable; output expired); all other logic is in the top module.

Verification
REQ-035 src_sel=1, debug generator sends a 4x2 frame, queue never full -> queue sees 10000, 10001, 4 pixels, 10001, 4 pixels, 1FFFF; active_src=10 during the frame; each word delayed by 1 cycle.
REQ-036 src_sel=0, camera frame in progress, src_sel toggled to 1 mid-frame -> the camera frame completes unchanged; the next forwarded FRAME_START comes from debug; dbg_full=1 until then.
REQ-037 CAM_FRAME, queue_full held high for 3 cam words -> those 3 words are absent from the queue; words_dropped=3 with the macro defined.
REQ-038 TIMEOUT_CYCLES=16, camera stops after 5 words -> 16 cycles after the last accepted word the FSM enters ABORT; 1FFFF is written with a one-cycle frame_aborted pulse; active_src=00 afterwards.
REQ-039 Reset asserted mid DBG_FRAME -> next cycle queue_wr_en=0 and active_src=00; no 1FFFF is written.
REQ-040 Camera sends FRAME_START mid-frame -> ABORT, 1FFFF written, the start word is discarded, the FSM returns to IDLE.

Source files
------------

// File: rtl/frame_queue_pkg.sv
// Shared frame-queue definitions: word markers and arbiter state.
// Used by the arbiter, debug pattern generator and camera capture.
package frame_queue_pkg;

  localparam logic [16:0] FRAME_START = 17'h10000;
  localparam logic [16:0] ROW_START   = 17'h10001;
  localparam logic [16:0] FRAME_END   = 17'h1FFFF;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_CAM  = 2'b01;
  localparam logic [1:0] SRC_DBG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAM_FRAME,
    ST_DBG_FRAME,
    ST_ABORT
  } arb_state_t;

endpackage

// File: rtl/frame_timeout_counter.sv
// Counts idle cycles inside a frame; expired is high on the
// TIMEOUT_CYCLES-th consecutive cycle without a clear.
module frame_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/frame_source_arbiter.sv
// Grants the frame queue to camera or debug source one whole frame at a time.
// Optional statistics outputs are enabled by FRAME_SOURCE_STATS_EN.
module frame_source_arbiter
  import frame_queue_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        src_sel,
  input  logic [16:0] cam_data,
  input  logic        cam_wr_en,
  input  logic [16:0] dbg_data,
  input  logic        dbg_wr_en,
  output logic        dbg_full,
  input  logic        queue_full,
  output logic [16:0] queue_data,
  output logic        queue_wr_en,
  output logic [1:0]  active_src,
`ifdef FRAME_SOURCE_STATS_EN
  output logic [15:0] frames_done,
  output logic [15:0] words_dropped,
`endif
  output logic        frame_aborted
);

  arb_state_t  state;
  arb_state_t  state_nxt;
  logic        use_dbg;
  logic        in_frame;
  logic        g_we;
  logic [16:0] g_data;
  logic        fwd;
  logic        ins_end;
  logic        expired;

  assign in_frame = (state == ST_CAM_FRAME) || (state == ST_DBG_FRAME);

  // In IDLE the requested source is watched; in a frame the granted one.
  assign use_dbg = (state == ST_DBG_FRAME) ||
                   (state == ST_IDLE && src_sel);
  assign g_we    = use_dbg ? dbg_wr_en : cam_wr_en;
  assign g_data  = use_dbg ? dbg_data  : cam_data;
  assign dbg_full = use_dbg ? queue_full : 1'b1;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (fwd || !in_frame),
    .enable (in_frame),
    .expired(expired)
  );

  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    ins_end   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (g_we && !queue_full && g_data == FRAME_START) begin
          fwd       = 1'b1;
          state_nxt = use_dbg ? ST_DBG_FRAME : ST_CAM_FRAME;
        end
      end
      ST_CAM_FRAME, ST_DBG_FRAME: begin
        if (g_we && g_data == FRAME_START) begin
          state_nxt = ST_ABORT;
        end else if (g_we && !queue_full) begin
          fwd = 1'b1;
          if (g_data == FRAME_END) state_nxt = ST_IDLE;
        end else if (g_we && g_data == FRAME_END) begin
          state_nxt = ST_ABORT;
        end else if (expired) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!queue_full) begin
          ins_end   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      queue_data    <= '0;
      queue_wr_en   <= 1'b0;
      frame_aborted <= 1'b0;
    end else begin
      state         <= state_nxt;
      queue_wr_en   <= fwd || ins_end;
      queue_data    <= ins_end ? FRAME_END : (fwd ? g_data : '0);
      frame_aborted <= ins_end;
    end
  end

  always_comb begin
    active_src = SRC_NONE;
    unique case (state)
      ST_CAM_FRAME: active_src = SRC_CAM;
      ST_DBG_FRAME: active_src = SRC_DBG;
      default:      active_src = SRC_NONE;
    endcase
  end

`ifdef FRAME_SOURCE_STATS_EN
  logic drop;
  logic end_wr;

  // A dropped FRAME_END turns into an abort, so it is not a lost word.
  assign drop = (state == ST_CAM_FRAME) && cam_wr_en && queue_full &&
                cam_data != FRAME_START && cam_data != FRAME_END;
  assign end_wr = ins_end || (fwd && g_data == FRAME_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_done   <= '0;
      words_dropped <= '0;
    end else begin
      if (end_wr) frames_done <= frames_done + 16'd1;
      if (drop) words_dropped <= words_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Directed and randomized checks of frame_source_arbiter
// against a cycle-level behavioural model of the arbitration rules.
module tb_frame_source_arbiter;
  import frame_queue_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        src_sel = 1'b0;
  logic [16:0] cam_data = '0;
  logic        cam_wr_en = 1'b0;
  logic [16:0] dbg_data = '0;
  logic        dbg_wr_en = 1'b0;
  logic        queue_full = 1'b0;
  logic        dbg_full;
  logic [16:0] queue_data;
  logic        queue_wr_en;
  logic [1:0]  active_src;
  logic        frame_aborted;
`ifdef FRAME_SOURCE_STATS_EN
  logic [15:0] frames_done;
  logic [15:0] words_dropped;
`endif

  int checks = 0;
  int errors = 0;

  // model: 0 none, 1 camera frame, 2 debug frame, 3 aborting
  int m_mode = 0;
  int m_idle = 0;
  int m_frames = 0;
  int m_drops = 0;
  int m_aborts = 0;
  int aborts_seen = 0;
  logic [16:0] got[$];

  always #5 clk = ~clk;

  frame_source_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_sel      (src_sel),
    .cam_data     (cam_data),
    .cam_wr_en    (cam_wr_en),
    .dbg_data     (dbg_data),
    .dbg_wr_en    (dbg_wr_en),
    .dbg_full     (dbg_full),
    .queue_full   (queue_full),
    .queue_data   (queue_data),
    .queue_wr_en  (queue_wr_en),
    .active_src   (active_src),
`ifdef FRAME_SOURCE_STATS_EN
    .frames_done  (frames_done),
    .words_dropped(words_dropped),
`endif
    .frame_aborted(frame_aborted)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic cwe, input logic [16:0] cd,
                      input logic dwe, input logic [16:0] dd,
                      input logic qf);
    logic        ewr;
    logic        eab;
    logic [16:0] ed;
    logic        we;
    logic [16:0] w;
    logic [1:0]  eact;
    logic        edf;
    src_sel = s;
    cam_wr_en = cwe;
    cam_data = cd;
    dbg_wr_en = dwe;
    dbg_data = dd;
    queue_full = qf;
    #1;
    eact = (m_mode == 1) ? 2'b01 : (m_mode == 2) ? 2'b10 : 2'b00;
    edf = (m_mode == 2 || (m_mode == 0 && s)) ? qf : 1'b1;
    chk("active_src", active_src, eact);
    chk("dbg_full", dbg_full, edf);
    ewr = 1'b0;
    eab = 1'b0;
    ed = '0;
    if (m_mode == 0) begin
      we = s ? dwe : cwe;
      w = s ? dd : cd;
      if (we && w == FRAME_START && !qf) begin
        ewr = 1'b1;
        ed = w;
        m_mode = s ? 2 : 1;
        m_idle = 0;
      end
    end else if (m_mode == 3) begin
      if (!qf) begin
        ewr = 1'b1;
        ed = FRAME_END;
        eab = 1'b1;
        m_mode = 0;
      end
    end else begin
      we = (m_mode == 2) ? dwe : cwe;
      w = (m_mode == 2) ? dd : cd;
      if (we && w == FRAME_START) m_mode = 3;
      else if (we && !qf) begin
        ewr = 1'b1;
        ed = w;
        m_idle = 0;
        if (w == FRAME_END) m_mode = 0;
      end else if (we && w == FRAME_END) m_mode = 3;
      else begin
        if (we && m_mode == 1) m_drops++;
        m_idle++;
        if (m_idle >= T) m_mode = 3;
      end
    end
    if (ewr && ed == FRAME_END) m_frames++;
    if (eab) m_aborts++;
    @(posedge clk);
    #1;
    chk("queue_wr_en", queue_wr_en, ewr);
    if (ewr) chk("queue_data", queue_data, ed);
    chk("frame_aborted", frame_aborted, eab);
    if (queue_wr_en) got.push_back(queue_data);
    if (frame_aborted) aborts_seen++;
  endtask

  task automatic cw(input logic s, input logic [16:0] w, input logic qf);
    step(s, 1'b1, w, 1'b0, '0, qf);
  endtask

  task automatic dw(input logic s, input logic [16:0] w, input logic qf);
    step(s, 1'b0, '0, 1'b1, w, qf);
  endtask

  task automatic nop(input logic s);
    step(s, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [16:0] rand_word();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return FRAME_START;
    if (r == 1) return FRAME_END;
    if (r == 2) return ROW_START;
    return {1'b0, 16'($urandom)};
  endfunction

  initial begin
    logic [16:0] exp_q[$];
    int lat;
    int ab0;
    int act;
    logic s;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", queue_wr_en, 1'b0);
    chk("rst_data", queue_data, 17'h0);
    chk("rst_aborted", frame_aborted, 1'b0);
    chk("rst_active", active_src, 2'b00);
    chk("rst_dbg_full", dbg_full, 1'b1);
`ifdef FRAME_SOURCE_STATS_EN
    chk("rst_frames", frames_done, 16'h0);
    chk("rst_drops", words_dropped, 16'h0);
`endif
    reset = 1'b0;

    // debug 4x2 frame, queue never full
    got.delete();
    exp_q = {FRAME_START, ROW_START};
    for (int i = 0; i < 4; i++) exp_q.push_back(17'h00010 + 17'(i));
    exp_q.push_back(ROW_START);
    for (int i = 0; i < 4; i++) exp_q.push_back(17'h00020 + 17'(i));
    exp_q.push_back(FRAME_END);
    nop(1'b1);
    foreach (exp_q[i]) dw(1'b1, exp_q[i], 1'b0);
    nop(1'b1);
    chk("dbg_frame_len", got.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got.size()) chk("dbg_frame_word", got[i], exp_q[i]);

    // camera frame survives a src_sel toggle
    got.delete();
    cw(1'b0, FRAME_START, 1'b0);
    cw(1'b0, ROW_START, 1'b0);
    step(1'b1, 1'b1, 17'h00123, 1'b1, FRAME_START, 1'b0);
    step(1'b1, 1'b1, 17'h00124, 1'b1, 17'h00055, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, FRAME_START, 1'b0);
    cw(1'b1, FRAME_END, 1'b0);
    step(1'b1, 1'b1, FRAME_START, 1'b1, FRAME_START, 1'b0);
    dw(1'b1, 17'h00077, 1'b0);
    dw(1'b1, FRAME_END, 1'b0);
    chk("toggle_len", got.size(), 8);
    if (got.size() == 8) begin
      chk("toggle_cam_end", got[4], FRAME_END);
      chk("toggle_dbg_px", got[6], 17'h00077);
    end

    // three camera words lost to queue_full
    got.delete();
    ab0 = m_drops;
    cw(1'b0, FRAME_START, 1'b0);
    cw(1'b0, 17'h00001, 1'b0);
    for (int i = 0; i < 3; i++) cw(1'b0, 17'h00100 + 17'(i), 1'b1);
    cw(1'b0, 17'h00002, 1'b0);
    cw(1'b0, FRAME_END, 1'b0);
    chk("drop_len", got.size(), 4);
    chk("drop_model", m_drops - ab0, 3);
`ifdef FRAME_SOURCE_STATS_EN
    chk("words_dropped", words_dropped, 16'(m_drops));
`endif

    // timeout after five accepted words
    cw(1'b0, FRAME_START, 1'b0);
    for (int i = 0; i < 4; i++) cw(1'b0, 17'h00200 + 17'(i), 1'b0);
    lat = 0;
    for (int k = 1; k <= T + 4; k++) begin
      nop(1'b0);
      if (frame_aborted && lat == 0) lat = k;
    end
    chk("timeout_latency", lat, T + 1);
    chk("timeout_after", active_src, 2'b00);

    // reset in the middle of a debug frame
    dw(1'b1, FRAME_START, 1'b0);
    dw(1'b1, 17'h00300, 1'b0);
    got.delete();
    dbg_wr_en = 1'b1;
    dbg_data = 17'h00301;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_mode = 0;
    m_idle = 0;
    m_frames = 0;
    m_drops = 0;
    chk("midrst_wr_en", queue_wr_en, 1'b0);
    chk("midrst_active", active_src, 2'b00);
    for (int i = 0; i < 4; i++) nop(1'b1);
    chk("midrst_no_end", got.size(), 0);

    // FRAME_START in the middle of a camera frame
    got.delete();
    ab0 = aborts_seen;
    cw(1'b0, FRAME_START, 1'b0);
    cw(1'b0, 17'h00400, 1'b0);
    cw(1'b0, FRAME_START, 1'b0);
    nop(1'b0);
    nop(1'b0);
    chk("restart_len", got.size(), 3);
    if (got.size() == 3) chk("restart_end", got[2], FRAME_END);
    chk("restart_abort", aborts_seen - ab0, 1);

    // randomized traffic in blocks of varying activity
    s = 1'b0;
    for (int b = 0; b < 20; b++) begin
      act = $urandom_range(0, 3);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 15) == 0) s = ~s;
        step(s,
             $urandom_range(0, 3) < act, rand_word(),
             $urandom_range(0, 3) < act, rand_word(),
             $urandom_range(0, 3) == 0);
      end
    end
    chk("abort_count", aborts_seen, m_aborts);
`ifdef FRAME_SOURCE_STATS_EN
    chk("frames_done", frames_done, 16'(m_frames));
    chk("words_dropped_rand", words_dropped, 16'(m_drops));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
